// File: rtl/random_word_packer.sv
// Packs a serial stream of random bits LSB-first into WIDTH-bit words and queues them in a DEPTH-entry FIFO.
// Latency: a completed word appears on out_data/out_valid the cycle after its final bit is accepted.
// Backpressure: bit_ready drops only while the word-completing bit is pending and the FIFO is full.
// Optional macro RANDOM_WORD_PACKER_PARITY_EN adds out_parity (even parity of the head word, stored per entry).
module random_word_packer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  output logic                     bit_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
`ifdef RANDOM_WORD_PACKER_PARITY_EN
  output logic                     out_parity,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int CNTW = $clog2(WIDTH);
`ifdef RANDOM_WORD_PACKER_PARITY_EN
  localparam int ENTRY_W = WIDTH + 1;
`else
  localparam int ENTRY_W = WIDTH;
`endif

  logic [CNTW-1:0]    bit_cnt;
  logic [WIDTH-2:0]   shift_q;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;

  logic               last_bit;
  logic               accept;
  logic               push;
  logic               pop;
  logic [WIDTH-1:0]   new_word;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head;

  // Handshake decode; the completing bit is the only one that ever waits on FIFO space
  always_comb begin
    last_bit   = (bit_cnt == CNTW'(WIDTH - 1));
    bit_ready  = !(last_bit && (count == CW'(DEPTH)));
    accept     = bit_valid && bit_ready;
    push       = accept && last_bit;
    out_valid  = (count != '0);
    pop        = out_valid && out_ready;
    new_word   = {bit_in, shift_q};
`ifdef RANDOM_WORD_PACKER_PARITY_EN
    push_entry = {^new_word, new_word};
`else
    push_entry = new_word;
`endif
    head       = mem[rd_ptr];
    out_data   = head[WIDTH-1:0];
`ifdef RANDOM_WORD_PACKER_PARITY_EN
    out_parity = head[WIDTH];
`endif
  end

  // Bit assembly, FIFO storage and occupancy; rst outranks clr, clr outranks handshakes
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      shift_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clr) begin
      // Stale entries stay in memory; count=0 keeps them hidden
      bit_cnt <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      if (accept) begin
        if (last_bit) begin
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + CNTW'(1);
        end
        // Bit k of the word lands in position k; the top bit bypasses the register
        for (int i = 0; i < WIDTH - 1; i++) begin
          if (bit_cnt == CNTW'(i)) begin
            shift_q[i] <= bit_in;
          end
        end
      end
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_random_word_packer.sv
// Self-checking bench for random_word_packer: queue-based reference model plus directed literal checks.
// Inputs change 1ns after the rising edge; outputs are compared on the falling edge.
// Define RANDOM_WORD_PACKER_PARITY_EN on both bench and RTL to cover the parity output.
module tb_random_word_packer;

  localparam int W = 8;
  localparam int D = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clr = 1'b0;
  logic              bit_in = 1'b0;
  logic              bit_valid = 1'b0;
  logic              bit_ready;
  logic [W-1:0]      out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [$clog2(D):0] count;
`ifdef RANDOM_WORD_PACKER_PARITY_EN
  logic              out_parity;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  bit rec_en = 1'b0;
  bit done   = 1'b0;

  logic [31:0] m_q[$];
  logic [31:0] m_part = '0;
  int          m_nbits = 0;
  logic [W-1:0] rec_q[$];

  logic [W-1:0] wtab [12] = '{8'hA5, 8'h3C, 8'h01, 8'hFE, 8'h80, 8'h7F,
                              8'h55, 8'hAA, 8'hC3, 8'h0F, 8'hF0, 8'h96};

  random_word_packer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef RANDOM_WORD_PACKER_PARITY_EN
    .out_parity(out_parity),
`endif
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one bit and holds it until the packer has taken it
  task automatic send_bit(input logic b);
    int guard;
    bit_valid = 1'b1;
    bit_in    = b;
    guard     = 0;
    while (!bit_ready && guard < 100) begin
      step(1);
      guard++;
    end
    checks++;
    if (!bit_ready) begin
      errors++;
      $display("FAIL send_bit_timeout actual=bit_ready0 required=bit_ready1 t=%0t", $time);
    end
    step(1);
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int b = 0; b < W; b++) begin
      send_bit(w[b]);
    end
  endtask

  task automatic drain();
    int guard;
    out_ready = 1'b1;
    guard     = 0;
    while (count != 0 && guard < 200) begin
      step(1);
      guard++;
    end
    checks++;
    if (count != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", count);
    end
    out_ready = 1'b0;
  endtask

  // Reference model: a partial-word accumulator and a queue of finished words
  always @(posedge clk) begin
    bit rdy, do_pop, do_acc;
    if (rst) begin
      m_nbits = 0;
      m_part  = '0;
      m_q.delete();
    end else if (clr) begin
      m_nbits = 0;
      m_q.delete();
    end else begin
      rdy    = !(m_nbits == W - 1 && m_q.size() == D);
      do_pop = (m_q.size() != 0) && out_ready;
      do_acc = bit_valid && rdy;
      if (do_pop) void'(m_q.pop_front());
      if (do_acc) begin
        m_part[m_nbits] = bit_in;
        m_nbits++;
        if (m_nbits == W) begin
          m_q.push_back(m_part);
          m_nbits = 0;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, plus pop recording
  always @(negedge clk) begin
    logic [W-1:0] hw;
    if (cmp_en) begin
      check("bit_ready", {31'd0, bit_ready}, {31'd0, !(m_nbits == W - 1 && m_q.size() == D)});
      check("out_valid", {31'd0, out_valid}, {31'd0, m_q.size() != 0});
      check("count", 32'(count), 32'(m_q.size()));
      if (m_q.size() != 0) begin
        hw = m_q[0][W-1:0];
        check("out_data", 32'(out_data), 32'(hw));
`ifdef RANDOM_WORD_PACKER_PARITY_EN
        check("out_parity", {31'd0, out_parity}, {31'd0, ^hw});
`endif
      end
      if (rec_en && out_valid && out_ready) rec_q.push_back(out_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    step(2);
    cmp_en = 1'b1;
    rst    = 1'b0;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_bit_ready", {31'd0, bit_ready}, 32'd1);
    check("rst_count", 32'(count), 32'd0);
`ifdef RANDOM_WORD_PACKER_PARITY_EN
    check("rst_parity", {31'd0, out_parity}, 32'd0);
`endif

    // Basic pack: 1,0,1,1,0,0,1,0 LSB-first -> 8'h4D
    send_bit(1); send_bit(0); send_bit(1); send_bit(1);
    send_bit(0); send_bit(0); send_bit(1); send_bit(0);
    check("pack_valid", {31'd0, out_valid}, 32'd1);
    check("pack_data", 32'(out_data), 32'h4D);
    check("pack_count", 32'(count), 32'd1);
`ifdef RANDOM_WORD_PACKER_PARITY_EN
    check("pack_parity_4d", {31'd0, out_parity}, 32'd0);
`endif

    // Fill and stall
    for (int i = 0; i < 24; i++) send_bit(logic'((i * 5 >> 1) & 1));
    check("fill_count", 32'(count), 32'd4);
    for (int i = 0; i < 7; i++) send_bit(logic'(i & 1));
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    step(2);
    check("stall_ready", {31'd0, bit_ready}, 32'd0);
    check("stall_count", 32'(count), 32'd4);
    check("stall_head", 32'(out_data), 32'h4D);

    // Concurrent push/pop: one pop releases the pending completing bit
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    check("pop_count", 32'(count), 32'd3);
    check("pop_ready", {31'd0, bit_ready}, 32'd1);
    step(1);
    bit_valid = 1'b0;
    check("refill_count", 32'(count), 32'd4);
    drain();

    // Pointer wrap with a half-rate consumer
    rec_q.delete();
    rec_en = 1'b1;
    done   = 1'b0;
    fork
      begin
        for (int k = 0; k < 12; k++) send_word(wtab[k]);
        bit_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = !out_ready;
          step(1);
        end
      end
    join
    drain();
    rec_en = 1'b0;
    check("wrap_n", 32'(rec_q.size()), 32'd12);
    for (int k = 0; k < 12 && k < rec_q.size(); k++) check("wrap_word", 32'(rec_q[k]), 32'(wtab[k]));

    // clr mid-word
    send_word(8'h12);
    send_word(8'h34);
    send_bit(1); send_bit(1); send_bit(0);
    clr       = 1'b1;
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    step(1);
    clr       = 1'b0;
    bit_valid = 1'b0;
    check("clr_count", 32'(count), 32'd0);
    check("clr_valid", {31'd0, out_valid}, 32'd0);
    send_word(8'hFF);
    bit_valid = 1'b0;
    check("clr_ff_data", 32'(out_data), 32'hFF);
    check("clr_ff_count", 32'(count), 32'd1);
`ifdef RANDOM_WORD_PACKER_PARITY_EN
    check("parity_ff", {31'd0, out_parity}, 32'd0);
`endif
    send_word(8'h01);
    bit_valid = 1'b0;
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    check("w01_data", 32'(out_data), 32'h01);
    check("w01_count", 32'(count), 32'd1);
`ifdef RANDOM_WORD_PACKER_PARITY_EN
    check("parity_01", {31'd0, out_parity}, 32'd1);
`endif
    send_word(8'h4D);
    check("pre_rst_count", 32'(count), 32'd2);

    // Reset mid-operation beats pop and bit handshakes
    rst       = 1'b1;
    out_ready = 1'b1;
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    step(1);
    rst       = 1'b0;
    out_ready = 1'b0;
    bit_valid = 1'b0;
    check("rst2_valid", {31'd0, out_valid}, 32'd0);
    check("rst2_data", 32'(out_data), 32'd0);
    check("rst2_ready", {31'd0, bit_ready}, 32'd1);
    check("rst2_count", 32'(count), 32'd0);
`ifdef RANDOM_WORD_PACKER_PARITY_EN
    check("rst2_parity", {31'd0, out_parity}, 32'd0);
`endif
    step(2);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/random_word_packer.md
Name: random_word_packer

Overview:
- Downstream consumer of the LFSR random engine datapath's serial output bit.
- Accepts one random bit per handshake and packs WIDTH consecutive bits into a word.
- Buffers completed words in a small FIFO and presents them on a valid/ready output.
- Backpressures the engine through bit_ready; the engine controller gates lfsr_en with it.

Parameters:
- WIDTH, 8, bits per packed word (2..32).
- DEPTH, 4, FIFO depth in words; power of 2, at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- clr  input  1  synchronous flush for reseed: discards the partial word and all FIFO contents.
- bit_in  input  1  random bit from the engine datapath output.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_ready  output  1  packer can accept a bit this cycle.
- out_data  output  WIDTH  packed word at the FIFO head.
- out_valid  output  1  FIFO is non-empty.
- out_ready  input  1  consumer accepts out_data this cycle.
- count  output  $clog2(DEPTH)+1  number of words currently stored.

Behaviour:
- Reset (rst=1 at an edge): bit counter 0, shift register 0, FIFO pointers 0, count 0, all FIFO entries 0.
  - Outputs after reset: out_valid=0, out_data=0, bit_ready=1.
  - rst has priority over clr and over every handshake in the same cycle.
- Bit accept: when bit_valid && bit_ready, bit_in is taken at the edge.
  - Bit ordering is LSB-first: the k-th accepted bit of a word (k=0..WIDTH-1) lands in bit k.
  - The bit counter increments, wrapping from WIDTH-1 to 0.
- Word completion: the accept of bit WIDTH-1 writes {bit_in, shift[WIDTH-2:0]} into the FIFO tail on the same edge.
  - The shift register is not cleared; it is overwritten bit by bit.
  - Latency: a completed word is visible on out_data/out_valid on the cycle after the final bit is accepted.
- bit_ready = !(bit_cnt == WIDTH-1 && count == DEPTH).
  - Bits 0..WIDTH-2 of the next word are accepted even while the FIFO is full; only the completing bit stalls.
  - bit_ready has no combinational dependence on out_ready or bit_valid.
- Output side: out_valid = (count != 0); out_data = the FIFO head entry.
  - Pop happens when out_valid && out_ready; the read pointer advances, mod DEPTH.
  - out_data must hold stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop: both pointers advance and count is unchanged.
  - Push into a full FIFO cannot occur, because bit_ready is low.
  - Pop from an empty FIFO is ignored.
- Pointers are $clog2(DEPTH) bits and wrap naturally. count tracks 0..DEPTH.
- clr=1 (and rst=0): bit counter, both pointers and count go to 0 on the edge.
  - A bit handshake in the same cycle is discarded.
  - A pop in the same cycle has no additional effect.
  - FIFO entries are not zeroed, but out_valid=0 hides them.
- No state machine beyond the bit counter and FIFO occupancy; the block is fully synchronous.

Optional Feature:
- Macro: RANDOM_WORD_PACKER_PARITY_EN.
- When defined:
  - Adds output port out_parity (1 bit) = XOR of the stored word, i.e. even-parity bit.
  - Parity is computed at push time and stored in the FIFO as a WIDTH+1-bit entry; it follows out_data and is 0 after reset.
- When undefined: the port and the extra storage do not exist; behaviour is otherwise identical.

Test Plan:
- Basic pack: rst, then WIDTH=8, bit_valid=1 with bits 1,0,1,1,0,0,1,0 in order, out_ready=0 -> on the cycle after the 8th bit, out_valid=1, out_data=8'h4D, count=1.
- Fill and stall: out_ready=0, continuous bit_valid=1 -> count reaches 4 after 32 bits; 7 more bits are accepted; bit_ready=0 with bit_cnt=7; out_data holds the first word.
- Concurrent push/pop: count=4 and stalled, then assert out_ready=1 for one cycle -> a pop occurs and count=3; bit_ready goes high the next cycle; the pending bit completes a push and count returns to 4.
- Pointer wrap: stream 12 words with out_ready toggling 1,0 -> all 12 words emerge in order with values matching the LSB-first reference model; no loss or duplication.
- clr mid-word: after 3 bits plus 2 stored words, pulse clr together with bit_valid=1 -> count=0, out_valid=0; the next 8 bits 8'hFF-pattern yield out_data=8'hFF.
- Reset mid-operation: rst with count=2 and out_ready=1 -> next cycle out_valid=0, out_data=0, bit_ready=1; with the macro defined, out_parity=0, and word 8'h4D gives out_parity=0 while 8'h01 gives 1.
